// File: rtl/ysyx_22041211_idu_stage.sv
// NPC decode stage: instruction queue from IFU, RV32I/M/Zicsr decoder,
// and a registered decoded bundle handed to EXU over valid/ready.
package ysyx_22041211_idu_pkg;
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;

  localparam logic [3:0] SEL_NONE  = 4'd0;
  localparam logic [3:0] SEL_RR    = 4'd1;
  localparam logic [3:0] SEL_RI    = 4'd2;
  localparam logic [3:0] SEL_PCIMM = 4'd3;
  localparam logic [3:0] SEL_IMM   = 4'd4;
  localparam logic [3:0] SEL_PC4   = 4'd5;
  localparam logic [3:0] SEL_CSR   = 4'd6;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  localparam logic [2:0] CSR_NONE  = 3'd0;
  localparam logic [2:0] CSR_RW    = 3'd1;
  localparam logic [2:0] CSR_RS    = 3'd2;
  localparam logic [2:0] CSR_ECALL = 3'd3;
  localparam logic [2:0] CSR_MRET  = 3'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  aluop;
    logic [3:0]  alusel;
    logic        wd;
    logic [4:0]  wreg;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic [31:0] imm;
    logic [2:0]  branch_type;
    logic [31:0] branch_target;
    logic [1:0]  store_type;
    logic [2:0]  load_type;
    logic        jmp_flag;
    logic        jalr;
    logic [31:0] jmp_target;
    logic [11:0] csr_addr;
    logic [2:0]  csr_flag;
    logic        muldiv;
    logic [2:0]  muldiv_op;
    logic        illegal;
  } id_ex_t;
endpackage

module ysyx_22041211_idu_stage
  import ysyx_22041211_idu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2,
  parameter int EN_M   = 0,
  parameter int EN_CSR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [31:0]     in_inst_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [3:0]      aluop_o,
  output logic [3:0]      alusel_o,
  output logic            wd_o,
  output logic [4:0]      wreg_o,
  output logic [4:0]      reg1_addr_o,
  output logic [4:0]      reg2_addr_o,
  output logic [31:0]     imm_o,
  output logic [2:0]      branch_type_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic [1:0]      store_type_o,
  output logic [2:0]      load_type_o,
  output logic            jmp_flag_o,
  output logic            jalr_o,
  output logic [XLEN-1:0] jmp_target_o,
  output logic [11:0]     csr_addr_o,
  output logic [2:0]      csr_flag_o,
  output logic            muldiv_o,
  output logic [2:0]      muldiv_op_o,
  output logic            illegal_o
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("XLEN must be 32");
  end
  if (QDEPTH < 2 || QDEPTH > 8 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_qd_chk
    $error("QDEPTH must be a power of two in 2..8");
  end

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_pc   [QDEPTH];
  logic [31:0]   mem_inst [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          load;
  logic          valid;
  id_ex_t        q;
  id_ex_t        d;

  assign in_ready_o = (count != CW'(QDEPTH));
  assign push = in_valid_i & in_ready_o;
  assign load = (count != '0) & (!valid | out_ready_i);

  // queue storage; pointers alone decide what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= in_pc_i;
      mem_inst[wr_ptr] <= in_inst_i;
    end
  end

  // queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(load);
    end
  end

  logic [31:0] inst, hpc;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ok;

  assign inst  = mem_inst[rd_ptr];
  assign hpc   = mem_pc[rd_ptr];
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign rd    = inst[11:7];
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  // decode the queue head into a full bundle
  always_comb begin
    d  = '0;
    ok = 1'b0;
    unique case (1'b1)
      opc == 7'b0110111: begin
        ok = 1'b1; d.wd = 1'b1; d.wreg = rd;
        d.imm = imm_u; d.alusel = SEL_IMM; d.aluop = ALU_ADD;
      end
      opc == 7'b0010111: begin
        ok = 1'b1; d.wd = 1'b1; d.wreg = rd;
        d.imm = imm_u; d.alusel = SEL_PCIMM; d.aluop = ALU_ADD;
      end
      opc == 7'b1101111: begin
        ok = 1'b1; d.wd = 1'b1; d.wreg = rd;
        d.imm = imm_j; d.alusel = SEL_PC4; d.aluop = ALU_ADD;
        d.jmp_flag = 1'b1; d.jmp_target = hpc + imm_j;
      end
      opc == 7'b1100111: begin
        ok = (f3 == 3'b000); d.wd = 1'b1; d.wreg = rd;
        d.reg1 = rs1; d.imm = imm_i; d.alusel = SEL_PC4;
        d.aluop = ALU_ADD; d.jmp_flag = 1'b1; d.jalr = 1'b1;
      end
      opc == 7'b1100011: begin
        ok = (f3 != 3'b010) && (f3 != 3'b011);
        d.reg1 = rs1; d.reg2 = rs2; d.imm = imm_b;
        d.alusel = SEL_RR; d.aluop = ALU_SUB;
        case (f3)
          3'b000:  d.branch_type = BR_BEQ;
          3'b001:  d.branch_type = BR_BNE;
          3'b100:  d.branch_type = BR_BLT;
          3'b101:  d.branch_type = BR_BGE;
          3'b110:  d.branch_type = BR_BLTU;
          default: d.branch_type = BR_BGEU;
        endcase
      end
      opc == 7'b0000011: begin
        ok = 1'b1; d.wd = 1'b1; d.wreg = rd; d.reg1 = rs1;
        d.imm = imm_i; d.alusel = SEL_RI; d.aluop = ALU_ADD;
        case (f3)
          3'b000:  d.load_type = 3'd1;
          3'b001:  d.load_type = 3'd2;
          3'b010:  d.load_type = 3'd3;
          3'b100:  d.load_type = 3'd4;
          3'b101:  d.load_type = 3'd5;
          default: ok = 1'b0;
        endcase
      end
      opc == 7'b0100011: begin
        ok = (f3 < 3'd3); d.reg1 = rs1; d.reg2 = rs2;
        d.imm = imm_s; d.alusel = SEL_RI; d.aluop = ALU_ADD;
        d.store_type = f3[1:0] + 2'd1;
      end
      opc == 7'b0010011: begin
        ok = 1'b1; d.wd = 1'b1; d.wreg = rd; d.reg1 = rs1;
        d.imm = imm_i; d.alusel = SEL_RI;
        case (f3)
          3'b000: d.aluop = ALU_ADD;
          3'b010: d.aluop = ALU_SLT;
          3'b011: d.aluop = ALU_SLTU;
          3'b100: d.aluop = ALU_XOR;
          3'b110: d.aluop = ALU_OR;
          3'b111: d.aluop = ALU_AND;
          3'b001: begin
            d.aluop = ALU_SLL; ok = (f7 == 7'b0);
          end
          default: begin
            d.aluop = (f7 == 7'b0) ? ALU_SRL : ALU_SRA;
            ok = (f7 == 7'b0) || (f7 == 7'b0100000);
          end
        endcase
      end
      opc == 7'b0110011: begin
        ok = 1'b1; d.wd = 1'b1; d.wreg = rd;
        d.reg1 = rs1; d.reg2 = rs2; d.alusel = SEL_RR;
        if (f7 == 7'b0) begin
          case (f3)
            3'b000:  d.aluop = ALU_ADD;
            3'b001:  d.aluop = ALU_SLL;
            3'b010:  d.aluop = ALU_SLT;
            3'b011:  d.aluop = ALU_SLTU;
            3'b100:  d.aluop = ALU_XOR;
            3'b101:  d.aluop = ALU_SRL;
            3'b110:  d.aluop = ALU_OR;
            default: d.aluop = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          ok = (f3 == 3'b000) || (f3 == 3'b101);
          d.aluop = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end else if (f7 == 7'b0000001) begin
          ok = (EN_M != 0); d.muldiv = 1'b1;
          d.muldiv_op = f3; d.aluop = ALU_NOP;
        end else begin
          ok = 1'b0;
        end
      end
      opc == 7'b1110011: begin
        if (inst == 32'h0000_0073) begin
          ok = 1'b1; d.jmp_flag = 1'b1; d.csr_flag = CSR_ECALL;
        end else if (inst == 32'h3020_0073) begin
          ok = 1'b1; d.jmp_flag = 1'b1; d.csr_flag = CSR_MRET;
          d.csr_addr = inst[31:20];
        end else if (f3 == 3'b001 || f3 == 3'b010) begin
          ok = 1'b1; d.wd = 1'b1; d.wreg = rd; d.reg1 = rs1;
          d.alusel = SEL_CSR; d.csr_addr = inst[31:20];
          d.csr_flag = (f3 == 3'b001) ? CSR_RW : CSR_RS;
        end
        if (EN_CSR == 0) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (ok) begin
      d.branch_target = hpc + d.imm;
    end else begin
      d = '0;
      d.illegal = 1'b1;
    end
    d.pc = hpc;
  end

  // output bundle register: load on pop, hold while stalled
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid <= 1'b0;
      if (rst) q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (out_ready_i) begin
      valid <= 1'b0;
    end
  end

  assign out_valid_o     = valid;
  assign pc_o            = q.pc;
  assign aluop_o         = q.aluop;
  assign alusel_o        = q.alusel;
  assign wd_o            = q.wd;
  assign wreg_o          = q.wreg;
  assign reg1_addr_o     = q.reg1;
  assign reg2_addr_o     = q.reg2;
  assign imm_o           = q.imm;
  assign branch_type_o   = q.branch_type;
  assign branch_target_o = q.branch_target;
  assign store_type_o    = q.store_type;
  assign load_type_o     = q.load_type;
  assign jmp_flag_o      = q.jmp_flag;
  assign jalr_o          = q.jalr;
  assign jmp_target_o    = q.jmp_target;
  assign csr_addr_o      = q.csr_addr;
  assign csr_flag_o      = q.csr_flag;
  assign muldiv_o        = q.muldiv;
  assign muldiv_op_o     = q.muldiv_op;
  assign illegal_o       = q.illegal;

endmodule

// File: doc/ysyx_22041211_idu_stage.md
Name: ysyx_22041211_idu_stage

Overview:
Registered RV32I(+M, +Zicsr) decode stage for the NPC pipeline, sitting between IFU and EXU. It accepts (pc, inst) from IFU over a valid/ready handshake into a small instruction queue. It decodes the queue head and holds one decoded bundle in an output register, also under valid/ready. Operand values are read downstream; this block emits only register addresses, immediates and control.

Parameters:
XLEN, 32, datapath/pc width; only 32 supported, asserted at elaboration.
QDEPTH, 2, instruction queue entries; power of two, 2..8.
EN_M, 0, 1 = decode RV32M (mul/mulh/mulhsu/mulhu/div/divu/rem/remu); 0 = those encodings are illegal.
EN_CSR, 1, 1 = decode csrrw/csrrs/ecall/mret; 0 = opcode 1110011 is illegal.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  discard queue and output bundle (redirect)
in_valid_i  in  1  IFU offers pc/inst
in_ready_o  out  1  queue can accept
in_pc_i  in  XLEN  instruction pc
in_inst_i  in  32  instruction word
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  EXU accepts bundle
pc_o  out  XLEN  pc of bundle
aluop_o  out  4  ALU op, define.v ALU_OP_* encodings
alusel_o  out  4  operand select, define.v ALU_SEL* encodings
wd_o  out  1  register write enable
wreg_o  out  5  rd
reg1_addr_o  out  5  rs1 (0 when unused)
reg2_addr_o  out  5  rs2 (0 when unused)
imm_o  out  32  sign-extended immediate per format
branch_type_o  out  3  BRANCH_* encoding
branch_target_o  out  XLEN  pc+imm, registered
store_type_o  out  2  STORE_* encoding
load_type_o  out  3  LOAD_* encoding
jmp_flag_o  out  1  unconditional jump (jal, jalr, ecall, mret)
jalr_o  out  1  target = rs1+imm, computed in EXU
jmp_target_o  out  XLEN  pc+imm for jal, else 0
csr_addr_o  out  12  inst[31:20]
csr_flag_o  out  3  CSR_* encoding
muldiv_o  out  1  M-extension op
muldiv_op_o  out  3  = func3 of M op
illegal_o  out  1  unsupported encoding

Behaviour:
- Reset (rst=1 at edge): queue empty, in_ready_o=1, out_valid_o=0, every bundle output 0.
- Queue: circular, rd/wr pointers plus count of log2(QDEPTH)+1 bits, wrapping modulo QDEPTH. in_ready_o = (count != QDEPTH), from registers only, no combinational path from out_ready_i. Push on in_valid_i & in_ready_o.
- Output register load condition: count != 0 & (!out_valid_o | out_ready_i). On load, pop the head, decode it combinationally, register the full bundle, set out_valid_o=1. If out_ready_i=1 with nothing to load, out_valid_o goes 0 next edge.
- Latency: inst pushed at edge k with empty queue and free/draining output appears with out_valid_o=1 after edge k+1. Sustained throughput 1 inst/cycle at QDEPTH>=2.
- Push and pop in the same cycle: count unchanged. Full queue with pop: in_ready_o stays 0 that cycle and rises next cycle.
- Bundle stability: while out_valid_o & !out_ready_i, all outputs hold.
- flush_i (priority below rst, above all else): next edge count=0, pointers=0, out_valid_o=0. A push and a load in the same cycle are both discarded.
- Decode: fields per define.v macros. Ecall matches the full word 0x00000073. Mret is 0x30200073 and sets jmp_flag_o with CSR_MRET. Slli/srli/srai require imm[11:5] of 0000000/0100000. M ops with EN_M=1: wd_o=1, muldiv_o=1, aluop_o=0.
- Illegal: any unmatched encoding, or an M/CSR encoding with its enable at 0, gives illegal_o=1 with wd_o=0, jmp_flag_o=0, store/load INVALID and other fields 0. The bundle is still delivered with out_valid_o=1.
- Arithmetic: branch_target_o and jmp_target_o wrap modulo 2^XLEN.

Test Plan:
- Reset then push pc=0x80000000 inst=0x00500093 (addi x1,x0,5) -> two edges later out_valid_o=1, wd_o=1, wreg_o=1, reg1_addr_o=0, imm_o=5, illegal_o=0.
- QDEPTH=2, out_ready_i=0, push 3 insts back-to-back -> in_ready_o=0 after 2nd push into the queue (3rd held by output register); then out_ready_i=1 -> order preserved, no loss or duplication.
- Push jal at pc=0xFFFFFFF0, imm=+0x20 -> jmp_flag_o=1, jmp_target_o=0x00000010 (wrap).
- EN_M=0, push 0x02208033 (mul) -> illegal_o=1, wd_o=0; EN_M=1 -> muldiv_o=1, muldiv_op_o=0, wd_o=1.
- Queue full and out_valid_o=1, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, and the flushed inst never appears.
- Push 0x00000073 -> jmp_flag_o=1, csr_flag_o=CSR_ECALL, wd_o=0. Push 0x00001073 with EN_CSR=0 -> illegal_o=1.
